pc_gen: RTL and testbench



---
 rtl/pc_gen.sv | 112 +++++++++++
 tb/tb_pc_gen.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: prioritised next-PC selection, EPC and BOOT/RUN/HANDLER/HALT control.
// Optional macro PC_MISALIGN_TRAP_EN turns misaligned redirects into traps; otherwise targets are word-aligned.
module pc_gen #(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR  = 32'hBFC00380,
    parameter int                    INC          = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_i,
    input  logic                  PCsrc,
    input  logic [DATA_WIDTH-1:0] PCTargetE_i,
    input  logic                  trap_i,
    input  logic [DATA_WIDTH-1:0] trap_pc_i,
    input  logic                  eret_i,
    output logic [DATA_WIDTH-1:0] PC,
    output logic [DATA_WIDTH-1:0] PC_Plus4,
    output logic                  pc_valid_o,
    output logic [DATA_WIDTH-1:0] epc_o,
    output logic                  in_handler_o,
    output logic                  halted_o,
    output logic                  misalign_o
);

    typedef enum logic [1:0] {
        ST_BOOT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HANDLER = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

    state_t                r_state, w_state_next;
    logic [DATA_WIDTH-1:0] r_pc, w_pc_next;
    logic [DATA_WIDTH-1:0] r_epc, w_epc_next;
    logic                  r_misalign, w_misalign_next;

    logic [DATA_WIDTH-1:0] w_pc_plus;
    logic [DATA_WIDTH-1:0] w_target;
    logic                  w_mis_trap;
    logic                  w_trap;

    assign w_pc_plus = r_pc + DATA_WIDTH'(INC);

`ifdef PC_MISALIGN_TRAP_EN
    // A misaligned taken redirect becomes a trap whose faulting PC is the bad target.
    assign w_mis_trap = PCsrc && (PCTargetE_i[1:0] != 2'b00);
    assign w_target   = PCTargetE_i;
`else
    assign w_mis_trap = 1'b0;
    assign w_target   = {PCTargetE_i[DATA_WIDTH-1:2], 2'b00};
`endif

    assign w_trap = trap_i || w_mis_trap;

    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_epc_next      = r_epc;
        w_misalign_next = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_state_next = ST_RUN;
            end
            ST_RUN, ST_HANDLER: begin
                if (w_trap) begin
                    w_pc_next       = TRAP_VECTOR;
                    w_misalign_next = !trap_i;
                    if (r_state == ST_RUN) begin
                        w_epc_next   = trap_i ? trap_pc_i : PCTargetE_i;
                        w_state_next = ST_HANDLER;
                    end else begin
                        w_state_next = ST_HALT;
                    end
                end else if (eret_i && (r_state == ST_HANDLER)) begin
                    w_pc_next    = r_epc;
                    w_state_next = ST_RUN;
                end else if (PCsrc) begin
                    w_pc_next = w_target;
                end else if (!stall_i) begin
                    w_pc_next = w_pc_plus;
                end
            end
            default: begin
                w_state_next = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_VECTOR;
            r_epc      <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_epc      <= w_epc_next;
            r_misalign <= w_misalign_next;
        end
    end

    assign PC           = r_pc;
    assign PC_Plus4     = w_pc_plus;
    assign epc_o        = r_epc;
    assign misalign_o   = r_misalign;
    assign pc_valid_o   = (r_state == ST_RUN) || (r_state == ST_HANDLER);
    assign in_handler_o = (r_state == ST_HANDLER);
    assign halted_o     = (r_state == ST_HALT);

endmodule

// File: tb/tb_pc_gen.sv
// Randomised bench for pc_gen against a behavioural fetch-PC model; honours PC_MISALIGN_TRAP_EN when defined.
module tb_pc_gen;

    localparam logic [31:0] RV = 32'hBFC00000;
    localparam logic [31:0] TV = 32'hBFC00380;

    logic        clk = 1'b0;
    logic        rst, stall_i, PCsrc, trap_i, eret_i;
    logic [31:0] PCTargetE_i, trap_pc_i;
    logic [31:0] PC, PC_Plus4, epc_o;
    logic        pc_valid_o, in_handler_o, halted_o, misalign_o;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .PCsrc(PCsrc),
        .PCTargetE_i(PCTargetE_i), .trap_i(trap_i), .trap_pc_i(trap_pc_i),
        .eret_i(eret_i), .PC(PC), .PC_Plus4(PC_Plus4), .pc_valid_o(pc_valid_o),
        .epc_o(epc_o), .in_handler_o(in_handler_o), .halted_o(halted_o),
        .misalign_o(misalign_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: mode is "boot", "run", "handler" or "halt" by name.
    string       m_mode;
    logic [31:0] m_pc, m_epc;
    logic        m_mis;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    endtask

    task automatic model_step();
        logic bad_target;
        bad_target = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        bad_target = PCsrc && (PCTargetE_i % 4 != 0);
`endif
        m_mis = 1'b0;
        if (rst) begin
            m_mode = "boot"; m_pc = RV; m_epc = 0;
        end else if (m_mode == "boot") begin
            m_mode = "run";
        end else if (m_mode == "halt") begin
            // frozen
        end else if (trap_i || bad_target) begin
            m_mis = !trap_i;
            m_pc  = TV;
            if (m_mode == "run") begin
                m_epc  = trap_i ? trap_pc_i : PCTargetE_i;
                m_mode = "handler";
            end else begin
                m_mode = "halt";
            end
        end else if (eret_i && m_mode == "handler") begin
            m_pc = m_epc; m_mode = "run";
        end else if (PCsrc) begin
            m_pc = PCTargetE_i - (PCTargetE_i % 4);
        end else if (!stall_i) begin
            m_pc = m_pc + 4;
        end
    endtask

    task automatic cycle(input logic r, input logic st, input logic ps, input logic [31:0] tgt,
                         input logic tr, input logic [31:0] tpc, input logic er);
        rst = r; stall_i = st; PCsrc = ps; PCTargetE_i = tgt;
        trap_i = tr; trap_pc_i = tpc; eret_i = er;
        @(posedge clk);
        model_step();
        #1;
        check_val("PC", PC, m_pc);
        check_val("PC_Plus4", PC_Plus4, m_pc + 32'd4);
        check_val("epc_o", epc_o, m_epc);
        check_val("pc_valid_o", {31'b0, pc_valid_o}, {31'b0, (m_mode == "run" || m_mode == "handler")});
        check_val("in_handler_o", {31'b0, in_handler_o}, {31'b0, m_mode == "handler"});
        check_val("halted_o", {31'b0, halted_o}, {31'b0, m_mode == "halt"});
        check_val("misalign_o", {31'b0, misalign_o}, {31'b0, m_mis});
        $display("cyc rst=%0b st=%0b ps=%0b tgt=%08h tr=%0b er=%0b -> PC=%08h epc=%08h v=%0b h=%0b x=%0b m=%0b",
                 r, st, ps, tgt, tr, er, PC, epc_o, pc_valid_o, in_handler_o, halted_o, misalign_o);
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        m_mode = "boot"; m_pc = RV; m_epc = 0; m_mis = 0;

        // Reset and boot
        cycle(1, 0, 0, 0, 0, 0, 0);
        check_val("reset_pc", PC, RV);
        check_val("reset_valid", {31'b0, pc_valid_o}, 32'd0);
        idle();
        check_val("boot_pc", PC, RV);
        check_val("boot_valid", {31'b0, pc_valid_o}, 32'd1);
        repeat (4) idle();
        check_val("seq_pc", PC, 32'hBFC00010);

        // Redirect overrides stall, then stall holds
        cycle(0, 1, 1, 32'h00001000, 0, 0, 0);
        check_val("redir_stall", PC, 32'h00001000);
        repeat (3) cycle(0, 1, 0, 0, 0, 0, 0);
        check_val("stall_hold", PC, 32'h00001000);

        // Trap and return
        cycle(0, 0, 0, 0, 1, 32'hBFC00020, 0);
        check_val("trap_pc", PC, TV);
        check_val("trap_epc", epc_o, 32'hBFC00020);
        repeat (3) idle();
        check_val("handler_inc", PC, TV + 32'd12);
        cycle(0, 0, 1, 32'h00002000, 0, 0, 1);
        check_val("eret_pc", PC, 32'hBFC00020);

        // Nested trap -> HALT, frozen despite inputs, rst recovers
        cycle(0, 0, 0, 0, 1, 32'h00000040, 0);
        cycle(0, 0, 0, 0, 1, 32'h00000080, 1);
        repeat (10) cycle(0, $urandom_range(1), 1, $urandom, 0, 0, 1);
        check_val("halt_pc", PC, TV);
        check_val("halt_flag", {31'b0, halted_o}, 32'd1);
        cycle(1, 0, 0, 0, 0, 0, 0);
        idle();

        // Wrap and trap-vs-redirect priority
        cycle(0, 0, 1, 32'hFFFFFFFC, 0, 0, 0);
        idle();
        check_val("wrap_pc", PC, 32'h00000000);
        cycle(0, 0, 1, 32'h00003000, 1, 32'h00000004, 0);
        check_val("trap_beats_redir", PC, TV);
        cycle(0, 0, 0, 0, 0, 0, 1);

        // Misaligned redirect
        cycle(0, 0, 1, 32'h00001002, 0, 0, 0);
`ifdef PC_MISALIGN_TRAP_EN
        check_val("mis_pc", PC, TV);
        check_val("mis_epc", epc_o, 32'h00001002);
        check_val("mis_pulse", {31'b0, misalign_o}, 32'd1);
        idle();
        check_val("mis_pulse_end", {31'b0, misalign_o}, 32'd0);
        cycle(0, 0, 0, 0, 0, 0, 1);
`else
        check_val("mis_pc", PC, 32'h00001000);
        check_val("mis_pulse", {31'b0, misalign_o}, 32'd0);
`endif

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] tgt;
            tgt = $urandom;
            if ($urandom_range(3) != 0) tgt[1:0] = 2'b00;
            cycle($urandom_range(150) == 0, $urandom_range(3) == 0, $urandom_range(5) == 0, tgt,
                  $urandom_range(30) == 0, $urandom, $urandom_range(8) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
